// File: rtl/mimo_frame_sequencer.sv
// mimo_frame_sequencer: frames host words into channel rows and data vectors
// for the MIMO detector, enforces credit against the local result FIFO, and
// tags the last result of each frame.
//
// state  | meaning
// IDLE   | one cycle between frames (and after reset); counters cleared
// LOAD_H | accepting N_RX channel rows, presented with det_flag=1
// LOAD_Y | accepting data vectors (det_flag=0), credit-limited
// DRAIN  | host blocked; waiting for the frame's last result to be taken
module mimo_frame_sequencer #(
  parameter int DATA_W    = 128,
  parameter int OUT_W     = 12,
  parameter int N_RX      = 4,
  parameter int OUT_DEPTH = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              det_in_valid,
  output logic              det_flag,
  output logic [DATA_W-1:0] det_data,
  input  logic              det_in_ready,
  input  logic              det_out_valid,
  input  logic [OUT_W-1:0]  det_out_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_last,
  output logic              frame_done,
  output logic              err
);

  localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int RW = (N_RX > 1) ? $clog2(N_RX) : 1;
  localparam int VW = 16;
  localparam logic [CW-1:0] DEPTH_C  = CW'(OUT_DEPTH);
  localparam logic [RW-1:0] LAST_ROW = RW'(N_RX - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD_H = 2'd1;
  localparam logic [1:0] ST_LOAD_Y = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [VW-1:0]     vec_cnt_q, vec_cnt_d;
  logic [VW-1:0]     res_cnt_q, res_cnt_d;
  logic [CW-1:0]     out_cnt_q, out_cnt_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              det_valid_q, det_valid_d;
  logic              det_flag_q, det_flag_d;
  logic [DATA_W-1:0] det_data_q, det_data_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q, err_d;
  logic [OUT_W-1:0]  mem_q [OUT_DEPTH];

  logic credit_ok, s_hs, vec_hs, fifo_full, no_out, res_ret, push, pop;

  // Handshake and occupancy decode; credit is the room left after counting
  // both vectors still inside the detector and results already queued.
  always_comb begin
    credit_ok = ({1'b0, out_cnt_q} + {1'b0, fifo_cnt_q}) < {1'b0, DEPTH_C};
    s_ready   = ((state_q == ST_LOAD_H) || ((state_q == ST_LOAD_Y) && credit_ok)) &&
                (!det_valid_q || det_in_ready);
    s_hs      = s_valid && s_ready;
    vec_hs    = s_hs && (state_q == ST_LOAD_Y);
    fifo_full = (fifo_cnt_q == DEPTH_C);
    no_out    = (out_cnt_q == '0);
    res_ret   = det_out_valid && !no_out;
    push      = res_ret && !fifo_full;
    m_valid   = (fifo_cnt_q != '0);
    m_data    = mem_q[rd_ptr_q];
    m_last    = m_valid && (state_q == ST_DRAIN) && ((res_cnt_q + VW'(1)) == vec_cnt_q);
    pop       = m_valid && m_ready;
  end

  // Frame sequencing state and per-frame counters.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    vec_cnt_d = vec_cnt_q + VW'(vec_hs);
    res_cnt_d = res_cnt_q + VW'(pop);
    case (state_q)
      ST_IDLE: begin
        state_d   = ST_LOAD_H;
        row_d     = '0;
        vec_cnt_d = '0;
        res_cnt_d = '0;
      end
      ST_LOAD_H: begin
        if (s_hs) begin
          if (row_q == LAST_ROW) begin
            state_d = ST_LOAD_Y;
            row_d   = '0;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      ST_LOAD_Y: if (s_hs && s_last) state_d = ST_DRAIN;
      ST_DRAIN:  if (frame_done_q) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Detector input register, FIFO pointers, credit bookkeeping and status.
  always_comb begin
    det_valid_d = det_valid_q;
    det_flag_d  = det_flag_q;
    det_data_d  = det_data_q;
    if (s_hs) begin
      det_valid_d = 1'b1;
      det_flag_d  = (state_q == ST_LOAD_H);
      det_data_d  = s_data;
    end else if (det_in_ready) begin
      det_valid_d = 1'b0;
    end
    out_cnt_d    = out_cnt_q + CW'(vec_hs) - CW'(res_ret);
    fifo_cnt_d   = fifo_cnt_q + CW'(push) - CW'(pop);
    wr_ptr_d     = wr_ptr_q + AW'(push);
    rd_ptr_d     = rd_ptr_q + AW'(pop);
    frame_done_d = pop && m_last;
    err_d        = err_q ||
                   (det_out_valid && (fifo_full || no_out)) ||
                   (s_valid && s_last && (state_q == ST_LOAD_H));
  end

  // State registers; reset drops any frame in progress along with its results.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      vec_cnt_q    <= '0;
      res_cnt_q    <= '0;
      out_cnt_q    <= '0;
      fifo_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      det_valid_q  <= 1'b0;
      det_flag_q   <= 1'b0;
      det_data_q   <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      vec_cnt_q    <= vec_cnt_d;
      res_cnt_q    <= res_cnt_d;
      out_cnt_q    <= out_cnt_d;
      fifo_cnt_q   <= fifo_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      det_valid_q  <= det_valid_d;
      det_flag_q   <= det_flag_d;
      det_data_q   <= det_data_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  // Result storage; contents need no reset since occupancy gates m_valid.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= det_out_data;
  end

  assign det_in_valid = det_valid_q;
  assign det_flag     = det_flag_q;
  assign det_data     = det_data_q;
  assign frame_done   = frame_done_q;
  assign err          = err_q;

endmodule
